// File: rtl/compute_clock_gate_ctrl_if.sv
// Host/requester bus of the compute-clock gate controller.
// Optional stall statistics ports appear when COMPUTE_CLOCK_GATE_STATS_EN is defined.
interface compute_clock_gate_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int COUNT_W = 48
);
  logic               start;
  logic               stop;
  logic [COUNT_W-1:0] cycle_budget;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               compute_clock_en_n;
  logic               running;
  logic               done;
  logic [COUNT_W-1:0] cycle_count;
`ifdef COMPUTE_CLOCK_GATE_STATS_EN
  logic [COUNT_W-1:0] stall_cycles;
  logic [15:0]        stall_events;

  modport master (
    output start, stop, cycle_budget, req,
    input  gnt, compute_clock_en_n, running, done, cycle_count, stall_cycles, stall_events
  );
  modport slave (
    input  start, stop, cycle_budget, req,
    output gnt, compute_clock_en_n, running, done, cycle_count, stall_cycles, stall_events
  );
`else
  modport master (
    output start, stop, cycle_budget, req,
    input  gnt, compute_clock_en_n, running, done, cycle_count
  );
  modport slave (
    input  start, stop, cycle_budget, req,
    output gnt, compute_clock_en_n, running, done, cycle_count
  );
`endif
endinterface

// File: rtl/compute_clock_gate_ctrl.sv
// Sequences the active-low compute-clock enable: budgeted runs, requester stalls with grants.
// Optional stall statistics are enabled by COMPUTE_CLOCK_GATE_STATS_EN.
module compute_clock_gate_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int COUNT_W      = 48,
  parameter int RESUME_DELAY = 2
) (
  input logic                    clock,
  input logic                    reset,
  compute_clock_gate_ctrl_if.slave bus
);
  localparam int DELAY_W = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY + 1) : 1;

  typedef enum logic [2:0] {IDLE, RUN, STALL, RESUME, DONE} state_t;

  state_t             state_reg;
  logic               en_n_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic               running_reg;
  logic               done_reg;
  logic [COUNT_W-1:0] cycle_count_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic [DELAY_W-1:0] delay_reg;
  logic               any_req;
  logic               last_cycle;

  assign any_req    = |bus.req;
  assign last_cycle = (remaining_reg == COUNT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      en_n_reg        <= 1'b1;
      gnt_reg         <= '0;
      running_reg     <= 1'b0;
      done_reg        <= 1'b0;
      cycle_count_reg <= '0;
      remaining_reg   <= '0;
      delay_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      // Every edge seen with the enable asserted is one compute-clock cycle.
      if (!en_n_reg) begin
        if (cycle_count_reg != '1) cycle_count_reg <= cycle_count_reg + 1'b1;
        remaining_reg <= remaining_reg - 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cycle_count_reg <= '0;
            if (bus.cycle_budget == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              remaining_reg <= bus.cycle_budget;
              state_reg     <= RUN;
              en_n_reg      <= 1'b0;
              running_reg   <= 1'b1;
            end
          end
        end
        RUN: begin
          // Budget exhaustion outranks stop and stall requests.
          if (last_cycle) begin
            state_reg   <= DONE;
            en_n_reg    <= 1'b1;
            running_reg <= 1'b0;
            done_reg    <= 1'b1;
          end else if (bus.stop) begin
            state_reg   <= IDLE;
            en_n_reg    <= 1'b1;
            running_reg <= 1'b0;
          end else if (any_req) begin
            state_reg <= STALL;
            en_n_reg  <= 1'b1;
          end
        end
        STALL: begin
          if (bus.stop) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            running_reg <= 1'b0;
          end else if (!any_req) begin
            gnt_reg <= '0;
            if (RESUME_DELAY == 0) begin
              state_reg <= RUN;
              en_n_reg  <= 1'b0;
            end else begin
              delay_reg <= DELAY_W'(RESUME_DELAY);
              state_reg <= RESUME;
            end
          end else begin
            gnt_reg <= bus.req;
          end
        end
        RESUME: begin
          if (bus.stop) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
          end else if (any_req) begin
            state_reg <= STALL;
          end else if (delay_reg == DELAY_W'(1)) begin
            state_reg <= RUN;
            en_n_reg  <= 1'b0;
          end else begin
            delay_reg <= delay_reg - 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt                = gnt_reg;
  assign bus.compute_clock_en_n = en_n_reg;
  assign bus.running            = running_reg;
  assign bus.done               = done_reg;
  assign bus.cycle_count        = cycle_count_reg;

`ifdef COMPUTE_CLOCK_GATE_STATS_EN
  logic [COUNT_W-1:0] stall_cycles_reg;
  logic [15:0]        stall_events_reg;
  logic               enter_stall;

  assign enter_stall = (state_reg == RUN) && !last_cycle && !bus.stop && any_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      stall_events_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      stall_cycles_reg <= '0;
      stall_events_reg <= '0;
    end else begin
      if (state_reg == STALL || state_reg == RESUME)
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      if (enter_stall && stall_events_reg != '1)
        stall_events_reg <= stall_events_reg + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cycles_reg;
  assign bus.stall_events = stall_events_reg;
`endif
endmodule

// File: tb/tb_compute_clock_gate_ctrl.sv
// Directed self-checking bench for compute_clock_gate_ctrl (RESUME_DELAY=2).
// Stats checks are compiled in when COMPUTE_CLOCK_GATE_STATS_EN is defined.
module tb_compute_clock_gate_ctrl;
  localparam int NUM_REQ = 4;
  localparam int COUNT_W = 48;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  compute_clock_gate_ctrl_if #(.NUM_REQ(NUM_REQ), .COUNT_W(COUNT_W)) bus ();

  compute_clock_gate_ctrl #(
    .NUM_REQ(NUM_REQ), .COUNT_W(COUNT_W), .RESUME_DELAY(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [COUNT_W-1:0] budget);
    bus.start        = 1'b1;
    bus.cycle_budget = budget;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.req = '0; bus.cycle_budget = '0;
    repeat (2) tick();
    check("rst_en_n",    64'(bus.compute_clock_en_n), 64'd1);
    check("rst_gnt",     64'(bus.gnt),                64'd0);
    check("rst_running", 64'(bus.running),            64'd0);
    check("rst_done",    64'(bus.done),               64'd0);
    check("rst_count",   64'(bus.cycle_count),        64'd0);
    reset = 1'b0;
    tick();

    // Budget 5, no stalls
    start_run(48'd5);
    for (int i = 0; i < 5; i++) begin
      check("b5_en_n_low", 64'(bus.compute_clock_en_n), 64'd0);
      check("b5_done_low", 64'(bus.done),               64'd0);
      check("b5_running",  64'(bus.running),            64'd1);
      tick();
    end
    check("b5_en_n_high", 64'(bus.compute_clock_en_n), 64'd1);
    check("b5_done",      64'(bus.done),               64'd1);
    check("b5_count",     64'(bus.cycle_count),        64'd5);
    tick();
    check("b5_done_once", 64'(bus.done),    64'd0);
    check("b5_idle",      64'(bus.running), 64'd0);

    // Budget 10, req[2] after 3 enabled cycles, held 4 cycles
    start_run(48'd10);
    tick(); tick();
    check("st_en_n_run", 64'(bus.compute_clock_en_n), 64'd0);
    bus.req = 4'b0100;
    tick();
    check("st_en_n_gated", 64'(bus.compute_clock_en_n), 64'd1);
    check("st_gnt_lat",    64'(bus.gnt),                64'd0);
    check("st_count3",     64'(bus.cycle_count),        64'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_gnt2",   64'(bus.gnt),                64'h4);
      check("st_en_n_1", 64'(bus.compute_clock_en_n), 64'd1);
    end
    bus.req = '0;
    tick();
    check("rs_gnt_clr", 64'(bus.gnt),                64'd0);
    check("rs_en_n_a",  64'(bus.compute_clock_en_n), 64'd1);
    tick();
    check("rs_en_n_b",  64'(bus.compute_clock_en_n), 64'd1);
    check("rs_running", 64'(bus.running),            64'd1);
    tick();
    for (int i = 0; i < 7; i++) begin
      check("st_en_n_low2", 64'(bus.compute_clock_en_n), 64'd0);
      check("st_done_low",  64'(bus.done),               64'd0);
      tick();
    end
    check("st_done",  64'(bus.done),        64'd1);
    check("st_count", 64'(bus.cycle_count), 64'd10);
`ifdef COMPUTE_CLOCK_GATE_STATS_EN
    check("st_stall_cycles", 64'(bus.stall_cycles), 64'd6);
    check("st_stall_events", 64'(bus.stall_events), 64'd1);
`endif
    tick();
    check("st_done_once", 64'(bus.done), 64'd0);

    // Budget 0
    start_run(48'd0);
    check("b0_en_n",    64'(bus.compute_clock_en_n), 64'd1);
    check("b0_done",    64'(bus.done),               64'd1);
    check("b0_count",   64'(bus.cycle_count),        64'd0);
    check("b0_running", 64'(bus.running),            64'd0);
    tick();
    check("b0_done_once", 64'(bus.done),               64'd0);
    check("b0_en_n_idle", 64'(bus.compute_clock_en_n), 64'd1);

    // Budget 100, stop after 7 enabled cycles
    start_run(48'd100);
    repeat (6) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("sp_en_n",    64'(bus.compute_clock_en_n), 64'd1);
    check("sp_running", 64'(bus.running),            64'd0);
    check("sp_done",    64'(bus.done),               64'd0);
    check("sp_count",   64'(bus.cycle_count),        64'd7);
    tick();
    check("sp_done_never", 64'(bus.done),        64'd0);
    check("sp_count_hold", 64'(bus.cycle_count), 64'd7);

    // Req reasserts in RESUME when the delay counter is at 1
    start_run(48'd50);
    bus.req = 4'b0001;
    tick();
    tick();
    check("rr_gnt_first", 64'(bus.gnt), 64'h1);
    bus.req = '0;
    tick();
    check("rr_gnt_drop", 64'(bus.gnt), 64'd0);
    tick();
    bus.req = 4'b0001;
    tick();
    check("rr_en_n_a", 64'(bus.compute_clock_en_n), 64'd1);
    check("rr_gnt_a",  64'(bus.gnt),                64'd0);
    tick();
    check("rr_en_n_b", 64'(bus.compute_clock_en_n), 64'd1);
    check("rr_gnt_b",  64'(bus.gnt),                64'h1);
    check("rr_count",  64'(bus.cycle_count),        64'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.req  = '0;
    check("rr_stop_gnt",  64'(bus.gnt),     64'd0);
    check("rr_stop_idle", 64'(bus.running), 64'd0);

    // Asynchronous reset while stalled with two grants
    start_run(48'd20);
    bus.req = 4'b0011;
    tick();
    tick();
    check("ar_gnt_pre", 64'(bus.gnt), 64'h3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_gnt",     64'(bus.gnt),                64'd0);
    check("ar_en_n",    64'(bus.compute_clock_en_n), 64'd1);
    check("ar_running", 64'(bus.running),            64'd0);
    check("ar_count",   64'(bus.cycle_count),        64'd0);
`ifdef COMPUTE_CLOCK_GATE_STATS_EN
    check("ar_stall_cycles", 64'(bus.stall_cycles), 64'd0);
`endif
    bus.req = '0;
    tick();
    reset = 1'b0;
    tick();
    start_run(48'd3);
    for (int i = 0; i < 3; i++) begin
      check("ar_b3_en_n_low", 64'(bus.compute_clock_en_n), 64'd0);
      tick();
    end
    check("ar_b3_done",  64'(bus.done),               64'd1);
    check("ar_b3_en_n",  64'(bus.compute_clock_en_n), 64'd1);
    check("ar_b3_count", 64'(bus.cycle_count),        64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
